// File: rtl/phy_rx_serial_paralelo.sv
// Serial-to-parallel lane receiver: comma alignment (HUNT/SYNC/ACTIVE) and byte delivery.
// Latency: byte outputs and byte_strobe update in the cycle after the edge sampling the last bit.
// No backpressure: the serial stream is free-running, so a byte is presented once per 8-clock slot.
module phy_rx_serial_paralelo #(
  parameter int              BYTE_W     = 8,
  parameter logic [BYTE_W-1:0] COMMA    = 8'hBC,
  parameter int              SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        bc_cnt_q, bc_cnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;

  logic [BYTE_W-1:0] nb;
  logic              is_comma;
  logic              slot_end;
  logic [3:0]        bc_inc;

  // Next-state logic: shift register, comma search, slot counting and byte capture.
  always_comb begin
    sr_d      = {sr_q[BYTE_W-2:0], data_in};
    nb        = sr_d;
    is_comma  = (nb == COMMA);
    slot_end  = (bit_cnt_q == 3'd7);
    bc_inc    = bc_cnt_q + 4'd1;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    case (state_q)
      HUNT: begin
        // Bit-level search; the detecting edge becomes the start of slot alignment.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = (SYNC_COUNT == 1) ? ACTIVE : SYNC;
        end
      end
      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (slot_end) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == 4'(SYNC_COUNT)) begin
              state_d = ACTIVE;
            end
          end else begin
            // Lost alignment: the search restarts from the next edge.
            bc_cnt_d = 4'd0;
            state_d  = HUNT;
          end
        end
      end
      ACTIVE: begin
        // Sticky: anything that is not a comma is delivered as data.
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (slot_end) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nb;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = HUNT;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = (state_q == ACTIVE);
  assign state_out   = state_q;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Bench for phy_rx_serial_paralelo: byte-level vector table plus hand-written reset and SYNC_COUNT=1 sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// No backpressure: serial bits are driven one per clock.
module tb_phy_rx_serial_paralelo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d0_strobe, d0_active;
  logic       d1_valid, d1_strobe, d1_active;
  logic [1:0] d0_state, d1_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phy_rx_serial_paralelo dut0 (
    .clk_32f(clk), .reset(rst_n), .data_in(din),
    .data_out(d0_data), .valid_out(d0_valid), .byte_strobe(d0_strobe),
    .active(d0_active), .state_out(d0_state)
  );

  phy_rx_serial_paralelo #(.SYNC_COUNT(1)) dut1 (
    .clk_32f(clk), .reset(rst_n), .data_in(din),
    .data_out(d1_data), .valid_out(d1_valid), .byte_strobe(d1_strobe),
    .active(d1_active), .state_out(d1_state)
  );

  typedef struct {
    logic [7:0] byte_v;
    logic [1:0] st;
    logic       act;
    logic       vld;
    logic       stb;
    logic [7:0] dat;
  } row_t;

  row_t rows [0:23];

  // Expected dut0 outputs held between slot completions.
  logic [1:0] e_st;
  logic       e_act, e_vld;
  logic [7:0] e_dat;

  function automatic row_t mk(logic [7:0] b, logic [1:0] st, logic act, logic vld, logic stb, logic [7:0] dat);
    row_t r;
    r.byte_v = b; r.st = st; r.act = act; r.vld = vld; r.stb = stb; r.dat = dat;
    return r;
  endfunction

  function automatic logic [12:0] pk(logic [7:0] d, logic v, logic s, logic a, logic [1:0] st);
    return {d, v, s, a, st};
  endfunction

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {data,valid,strobe,active,state}=%h_%b%b%b_%0d required %h_%b%b%b_%0d",
               nm, got[12:5], got[4], got[3], got[2], got[1:0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic tick(input logic r, input logic b);
    rst_n = r;
    din   = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] dut0_vec();
    return pk(d0_data, d0_valid, d0_strobe, d0_active, d0_state);
  endfunction

  function automatic logic [12:0] dut1_vec();
    return pk(d1_data, d1_valid, d1_strobe, d1_active, d1_state);
  endfunction

  task automatic set_exp_zero();
    e_st = 2'd0; e_act = 1'b0; e_vld = 1'b0; e_dat = 8'h00;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      chk("reset", dut0_vec(), pk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    set_exp_zero();
  endtask

  // Send table rows MSB first; mid-slot outputs must hold, slot end must match the row.
  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int b = 7; b >= 0; b--) begin
        tick(1'b1, rows[i].byte_v[b]);
        if (b != 0) begin
          chk($sformatf("row%0d_mid%0d", i, b), dut0_vec(), pk(e_dat, e_vld, 1'b0, e_act, e_st));
        end else begin
          e_st = rows[i].st; e_act = rows[i].act; e_vld = rows[i].vld; e_dat = rows[i].dat;
          chk($sformatf("row%0d_end", i), dut0_vec(), pk(e_dat, e_vld, rows[i].stb, e_act, e_st));
        end
      end
    end
  endtask

  initial begin
    logic [7:0] pat;

    // Alignment and data delivery.
    rows[0]  = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rows[1]  = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[2]  = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[3]  = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    rows[4]  = mk(8'hFF, 2'd2, 1'b1, 1'b1, 1'b1, 8'hFF);
    rows[5]  = mk(8'hEE, 2'd2, 1'b1, 1'b1, 1'b1, 8'hEE);
    rows[6]  = mk(8'hDD, 2'd2, 1'b1, 1'b1, 1'b1, 8'hDD);
    rows[7]  = mk(8'hCC, 2'd2, 1'b1, 1'b1, 1'b1, 8'hCC);
    rows[8]  = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'hCC);
    rows[9]  = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'hCC);
    rows[10] = mk(8'h03, 2'd2, 1'b1, 1'b1, 1'b1, 8'h03);
    rows[11] = mk(8'h04, 2'd2, 1'b1, 1'b1, 1'b1, 8'h04);
    rows[12] = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'h04);
    // Re-lock after a mid-byte reset.
    rows[13] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rows[14] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[15] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[16] = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    // Broken sync: a data byte during SYNC drops back to HUNT.
    rows[17] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rows[18] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[19] = mk(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[20] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rows[21] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[22] = mk(8'hBC, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    rows[23] = mk(8'hBC, 2'd2, 1'b1, 1'b0, 1'b1, 8'h00);

    rst_n = 1'b0;
    din   = 1'b0;

    do_reset(4);

    // Three garbage bits before the first comma: still hunting.
    pat = 8'b0000_0101;
    for (int b = 2; b >= 0; b--) begin
      tick(1'b1, pat[b]);
      chk($sformatf("garbage%0d", b), dut0_vec(), pk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0));
    end

    // active rises at the slot that completes the 4th comma (35 clocks after release).
    run_rows(0, 12);

    // Reset for one clock after four bits of 0xEE while active.
    pat = 8'hEE;
    for (int b = 7; b >= 4; b--) begin
      tick(1'b1, pat[b]);
      chk($sformatf("ee_bit%0d", b), dut0_vec(), pk(e_dat, e_vld, 1'b0, e_act, e_st));
    end
    tick(1'b0, 1'b0);
    chk("midop_reset", dut0_vec(), pk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0));
    set_exp_zero();
    run_rows(13, 16);

    do_reset(2);
    run_rows(17, 23);

    // SYNC_COUNT=1 instance: one comma activates the lane on the detect edge.
    do_reset(1);
    pat = 8'hBC;
    for (int b = 7; b >= 0; b--) tick(1'b1, pat[b]);
    chk("sc1_detect", dut1_vec(), pk(8'h00, 1'b0, 1'b0, 1'b1, 2'd2));
    pat = 8'h5A;
    for (int b = 7; b >= 0; b--) begin
      tick(1'b1, pat[b]);
      if (b != 0)
        chk($sformatf("sc1_mid%0d", b), dut1_vec(), pk(8'h00, 1'b0, 1'b0, 1'b1, 2'd2));
      else
        chk("sc1_data", dut1_vec(), pk(8'h5A, 1'b1, 1'b1, 1'b1, 2'd2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
